// File: rtl/conv_bram_stream_reader.sv
// conv_bram_stream_reader: credit-based BRAM read sequencer feeding a 2-deep valid/ready stream buffer
module conv_bram_stream_reader #(
  parameter int RAM_WIDTH = 64,
  parameter int RAM_DEPTH = 11,
  parameter int ADDR_W    = 4
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic                 bram_en,
  output logic                 bram_we,
  input  logic [RAM_WIDTH-1:0] bram_dout,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W:0]      rem_q, rem_d, beats_q, beats_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 infl_q;
  logic [RAM_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                 pop;
  assign pop       = m_valid & m_ready;
  assign m_valid   = cnt_q != 2'd0;
  assign m_data    = buf0_q;
  assign m_last    = m_valid & (beats_q == (ADDR_W+1)'(1));
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign bram_addr = addr_q;
  assign bram_we   = 1'b0;
  // a read is issued only if buffered words plus the in-flight word, less a same-cycle pop, leave a free slot
  assign bram_en   = (state_q == RUN) & (rem_q != '0) &
                     ({1'b0, cnt_q} + {2'b0, infl_q} < 3'd2 + {2'b0, pop});
  // next state for sequencing and buffer; the in-flight flag marks bram_dout as a word to push this cycle
  always_comb begin
    state_d = state_q;
    addr_d  = bram_en ? ((addr_q == ADDR_W'(RAM_DEPTH-1)) ? '0 : addr_q + 1'b1) : addr_q;
    rem_d   = bram_en ? rem_q - 1'b1 : rem_q;
    beats_d = pop ? beats_q - 1'b1 : beats_q;
    cnt_d   = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    buf0_d  = pop ? ((cnt_q == 2'd2) ? buf1_q : (infl_q ? bram_dout : buf0_q))
                  : ((infl_q && cnt_q == 2'd0) ? bram_dout : buf0_q);
    buf1_d  = (infl_q && cnt_q == 2'd1 && !pop) ? bram_dout : buf1_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (len != '0) ? RUN : DONE;
        addr_d  = base_addr;
        rem_d   = len;
        beats_d = len;
      end
      RUN:     if (bram_en && rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
      DRAIN:   if (pop && m_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // register everything; reset aborts the command and drops any read still in flight
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      infl_q  <= 1'b0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      infl_q  <= bram_en;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end
endmodule

// File: tb/tb_conv_bram_stream_reader.sv
// tb_conv_bram_stream_reader: directed checks of the BRAM stream reader against a BRAM model and beat scoreboard
module tb_conv_bram_stream_reader;
  localparam int W = 64, D = 11, AW = 4;
  logic          clka = 0, rsta = 0, start = 0, m_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, bram_en, bram_we, m_valid, m_last;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_dout = '0, m_data;
  logic [W-1:0]  mem [D];
  int            errors = 0, checks = 0;
  int            cmd_base = 0, cmd_len = 0, iss = 0, beats = 0, outst = 0;
  logic          hold = 0, hlast = 0;
  logic [W-1:0]  hdata = '0;

  always #5 clka = ~clka;

  conv_bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_W(AW)) dut (
    .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_dout(bram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  // single-port BRAM, 1-cycle read latency
  always @(posedge clka) if (bram_en) bram_dout <= mem[bram_addr];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // per-cycle monitor: address sequence, credit limit, beat data/last, stability under backpressure
  always @(negedge clka) if (rsta) begin
    chk("we_zero", W'(bram_we), W'(0));
    if (hold) begin
      chk("hold_valid", W'(m_valid), W'(1));
      chk("hold_data", m_data, hdata);
      chk("hold_last", W'(m_last), W'(hlast));
    end
    if (bram_en) begin
      chk("addr", W'(bram_addr), W'((cmd_base + iss) % D));
      chk("credit", W'(outst - int'(m_valid && m_ready) < 2), W'(1));
      iss++;
    end
    if (m_valid && m_ready) begin
      chk("beat_data", m_data, mem[(cmd_base + beats) % D]);
      chk("beat_last", W'(m_last), W'(beats == cmd_len - 1));
      beats++;
    end
    outst += int'(bram_en) - int'(m_valid && m_ready);
    hold  = m_valid & ~m_ready;
    hdata = m_data;
    hlast = m_last;
  end

  task automatic do_start(input int b, input int l);
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    start     = 1;
    cmd_base  = b;
    cmd_len   = l;
    iss       = 0;
    beats     = 0;
    @(posedge clka); #1 start = 0;
  endtask

  task automatic wait_done(input logic [15:0] pat);
    int k = 0;
    while (!done && k < 200) begin
      m_ready = pat[k % 16];
      @(posedge clka); #1;
      k++;
    end
    chk("done_timeout", W'(done), W'(1));
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_en"}, W'(bram_en), W'(0));
    chk({tag, "_addr"}, W'(bram_addr), W'(0));
    chk({tag, "_valid"}, W'(m_valid), W'(0));
    chk({tag, "_last"}, W'(m_last), W'(0));
    chk({tag, "_data"}, m_data, W'(0));
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'('h100 + i);
    repeat (2) @(posedge clka);
    #1 chk_idle_outs("reset");
    rsta = 1; m_ready = 1;
    @(posedge clka); #1;
    // T1: base 2, len 4, ready held
    do_start(2, 4);
    chk("t1_en_c0", W'(bram_en), W'(1));
    chk("t1_busy", W'(busy), W'(1));
    chk("t1_valid_c0", W'(m_valid), W'(0));
    @(posedge clka); #1 chk("t1_valid_c1", W'(m_valid), W'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clka); #1;
      chk("t1_valid", W'(m_valid), W'(1));
      chk("t1_data", m_data, W'('h102 + i));
      chk("t1_last", W'(m_last), W'(i == 3));
      chk("t1_nodone", W'(done), W'(0));
    end
    @(posedge clka); #1;
    chk("t1_done", W'(done), W'(1));
    chk("t1_valid_end", W'(m_valid), W'(0));
    chk("t1_busy_done", W'(busy), W'(1));
    chk("t1_beats", W'(beats), W'(4));
    // start during the done cycle is ignored
    base_addr = AW'(5); len = (AW+1)'(2); start = 1;
    @(posedge clka); #1 start = 0;
    chk("ign_done_busy", W'(busy), W'(0));
    chk("ign_done_en", W'(bram_en), W'(0));
    @(posedge clka); #1;
    // T2: wrap 9,10,0,1,2
    do_start(9, 5);
    wait_done(16'hFFFF);
    chk("t2_iss", W'(iss), W'(5));
    chk("t2_beats", W'(beats), W'(5));
    @(posedge clka); #1;
    // T3: backpressure pattern
    do_start(3, 4);
    wait_done(16'hB469);
    chk("t3_iss", W'(iss), W'(4));
    chk("t3_beats", W'(beats), W'(4));
    m_ready = 1;
    @(posedge clka); #1;
    // T4: len 0
    do_start(0, 0);
    chk("t4_done", W'(done), W'(1));
    chk("t4_en", W'(bram_en), W'(0));
    chk("t4_valid", W'(m_valid), W'(0));
    @(posedge clka); #1;
    chk("t4_done_off", W'(done), W'(0));
    chk("t4_busy_off", W'(busy), W'(0));
    chk("t4_iss", W'(iss), W'(0));
    chk("t4_beats", W'(beats), W'(0));
    // T5: reset mid-command
    do_start(0, 8);
    repeat (2) @(posedge clka);
    #1 rsta = 0; hold = 0; outst = 0;
    #1 chk_idle_outs("t5_rst");
    @(posedge clka); #1 rsta = 1;
    chk("t5_nodone", W'(done), W'(0));
    @(posedge clka); #1;
    do_start(0, 2);
    wait_done(16'hFFFF);
    chk("t5_iss", W'(iss), W'(2));
    chk("t5_beats", W'(beats), W'(2));
    repeat (4) @(posedge clka);
    #1 chk("t5_no_extra", W'(beats), W'(2));
    chk("t5_idle", W'(busy), W'(0));
    // T6: start while busy is ignored
    do_start(1, 3);
    @(posedge clka); #1;
    base_addr = AW'(5); len = (AW+1)'(2); start = 1;
    @(posedge clka); #1 start = 0;
    wait_done(16'hFFFF);
    chk("t6_iss", W'(iss), W'(3));
    chk("t6_beats", W'(beats), W'(3));
    @(posedge clka); #1;
    chk("t6_idle", W'(busy), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
